// File: rtl/exec_pkg.sv
// Shared constants, state encoding and control word for the execute FSM.
// Optional MFC watchdog is enabled with EXEC_MFC_TIMEOUT_EN.
package exec_pkg;

    localparam int IR_WIDTH  = 16;
    localparam int SEL_WIDTH = 4;
    localparam int MFC_TIMEOUT_DEF = 15;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 8;
    localparam int RS_LSB = 4;
    localparam int FLD_W  = 4;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_MOVI  = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_DECODE,
        S_A1, S_A2, S_A3,
        S_L1, S_L2, S_L3,
        S_S1, S_S2, S_S3,
        S_M1, S_J1,
        S_DONE, S_HALT
`ifdef EXEC_MFC_TIMEOUT_EN
        , S_BERR
`endif
    } state_t;

    typedef struct packed {
        logic                 reg_out_en;
        logic [SEL_WIDTH-1:0] reg_out_sel;
        logic                 reg_in_en;
        logic [SEL_WIDTH-1:0] reg_in_sel;
        logic                 y_in;
        logic [1:0]           alu_op;
        logic                 z_in;
        logic                 z_out_en;
        logic                 imm_out_en;
        logic                 mar_in;
        logic                 mdr_bus_in;
        logic                 mdr_out_en;
        logic                 en;
        logic                 rw;
        logic                 pc_in;
        logic                 done;
        logic                 halted;
        logic                 illegal;
`ifdef EXEC_MFC_TIMEOUT_EN
        logic                 bus_err;
`endif
    } ctrl_t;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    // ALU opcodes 1..4 map directly onto ALU functions 0..3
    function automatic logic [1:0] alu_of(input logic [3:0] op);
        logic [3:0] t;
        t = op - 4'd1;
        return t[1:0];
    endfunction

endpackage

// File: rtl/exec_decode.sv
// Moore decode: state plus latched IR fields to the datapath control word.
module exec_decode
    import exec_pkg::*;
(
    input  state_t               state,
    input  logic [FLD_W-1:0]     op,
    input  logic [SEL_WIDTH-1:0] rd,
    input  logic [SEL_WIDTH-1:0] rs,
    output ctrl_t                ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_DECODE: ctrl.illegal = !is_legal(op);
            S_A1: begin
                ctrl.reg_out_en  = 1'b1;
                ctrl.reg_out_sel = rd;
                ctrl.y_in        = 1'b1;
            end
            S_A2: begin
                ctrl.reg_out_en  = 1'b1;
                ctrl.reg_out_sel = rs;
                ctrl.alu_op      = alu_of(op);
                ctrl.z_in        = 1'b1;
            end
            S_A3: begin
                ctrl.z_out_en   = 1'b1;
                ctrl.reg_in_en  = 1'b1;
                ctrl.reg_in_sel = rd;
            end
            S_L1: begin
                ctrl.reg_out_en  = 1'b1;
                ctrl.reg_out_sel = rs;
                ctrl.mar_in      = 1'b1;
            end
            S_L2: begin
                ctrl.en = 1'b1;
                ctrl.rw = 1'b1;
            end
            S_L3: begin
                ctrl.mdr_out_en = 1'b1;
                ctrl.reg_in_en  = 1'b1;
                ctrl.reg_in_sel = rd;
            end
            S_S1: begin
                ctrl.reg_out_en  = 1'b1;
                ctrl.reg_out_sel = rd;
                ctrl.mar_in      = 1'b1;
            end
            S_S2: begin
                ctrl.reg_out_en  = 1'b1;
                ctrl.reg_out_sel = rs;
                ctrl.mdr_bus_in  = 1'b1;
            end
            S_S3: ctrl.en = 1'b1;
            S_M1: begin
                ctrl.imm_out_en = 1'b1;
                ctrl.reg_in_en  = 1'b1;
                ctrl.reg_in_sel = rd;
            end
            S_J1: begin
                ctrl.reg_out_en  = 1'b1;
                ctrl.reg_out_sel = rs;
                ctrl.pc_in       = 1'b1;
            end
            S_DONE: ctrl.done = 1'b1;
            S_HALT: ctrl.halted = 1'b1;
`ifdef EXEC_MFC_TIMEOUT_EN
            S_BERR: ctrl.bus_err = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage control FSM: IR latch, sequencing and MFC handshake.
// Define EXEC_MFC_TIMEOUT_EN to add the MFC watchdog and bus_err output.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int IR_W        = IR_WIDTH,
    parameter int SEL_W       = SEL_WIDTH,
    parameter int MFC_TIMEOUT = MFC_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done_fetch,
    input  logic [IR_W-1:0]  ir,
    input  logic             MFC,
    output logic             reg_out_en,
    output logic [SEL_W-1:0] reg_out_sel,
    output logic             reg_in_en,
    output logic [SEL_W-1:0] reg_in_sel,
    output logic             y_in,
    output logic [1:0]       alu_op,
    output logic             z_in,
    output logic             z_out_en,
    output logic             imm_out_en,
    output logic             MARin,
    output logic             MDR_frombusin,
    output logic             MDROutEn,
    output logic             EN,
    output logic             RW,
    output logic             PCin,
    output logic             done,
    output logic             halted,
`ifdef EXEC_MFC_TIMEOUT_EN
    output logic             bus_err,
`endif
    output logic             illegal
);

    state_t state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [FLD_W-1:0] op;
    ctrl_t ctrl;
    logic unused_imm;

    assign op = ir_q[OP_LSB +: FLD_W];
    assign unused_imm = ^ir_q[RS_LSB-1:0];

`ifdef EXEC_MFC_TIMEOUT_EN
    localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic tmo;

    always_comb begin
        cnt_d = '0;
        if (state_q == S_L2 || state_q == S_S3)
            cnt_d = cnt_q + CNT_W'(1);
        tmo = (state_q == S_L2 || state_q == S_S3) && !MFC
              && (cnt_q == CNT_W'(MFC_TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (done_fetch) begin
                    ir_d    = ir;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (op)
                    OP_ADD, OP_SUB,
                    OP_AND, OP_OR: state_d = S_A1;
                    OP_LOAD:       state_d = S_L1;
                    OP_STORE:      state_d = S_S1;
                    OP_MOVI:       state_d = S_M1;
                    OP_JMP:        state_d = S_J1;
                    OP_HALT:       state_d = S_HALT;
                    default:       state_d = S_DONE;
                endcase
            end
            S_A1: state_d = S_A2;
            S_A2: state_d = S_A3;
            S_A3: state_d = S_DONE;
            S_L1: state_d = S_L2;
            S_L2: begin
                if (MFC) state_d = S_L3;
`ifdef EXEC_MFC_TIMEOUT_EN
                else if (tmo) state_d = S_BERR;
`endif
            end
            S_L3: state_d = S_DONE;
            S_S1: state_d = S_S2;
            S_S2: state_d = S_S3;
            S_S3: begin
                if (MFC) state_d = S_DONE;
`ifdef EXEC_MFC_TIMEOUT_EN
                else if (tmo) state_d = S_BERR;
`endif
            end
            S_M1:   state_d = S_DONE;
            S_J1:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            S_HALT: state_d = S_HALT;
`ifdef EXEC_MFC_TIMEOUT_EN
            S_BERR: state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    exec_decode u_dec (
        .state (state_q),
        .op    (op),
        .rd    (ir_q[RD_LSB +: SEL_WIDTH]),
        .rs    (ir_q[RS_LSB +: SEL_WIDTH]),
        .ctrl  (ctrl)
    );

    assign reg_out_en    = ctrl.reg_out_en;
    assign reg_out_sel   = ctrl.reg_out_sel;
    assign reg_in_en     = ctrl.reg_in_en;
    assign reg_in_sel    = ctrl.reg_in_sel;
    assign y_in          = ctrl.y_in;
    assign alu_op        = ctrl.alu_op;
    assign z_in          = ctrl.z_in;
    assign z_out_en      = ctrl.z_out_en;
    assign imm_out_en    = ctrl.imm_out_en;
    assign MARin         = ctrl.mar_in;
    assign MDR_frombusin = ctrl.mdr_bus_in;
    assign MDROutEn      = ctrl.mdr_out_en;
    assign EN            = ctrl.en;
    assign RW            = ctrl.rw;
    assign PCin          = ctrl.pc_in;
    assign done          = ctrl.done;
    assign halted        = ctrl.halted;
    assign illegal       = ctrl.illegal;
`ifdef EXEC_MFC_TIMEOUT_EN
    assign bus_err       = ctrl.bus_err;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed self-checking bench for exec_ctrl.
// Timeout test runs only when EXEC_MFC_TIMEOUT_EN is defined.
module tb_exec_ctrl;

    typedef struct packed {
        logic       roe;
        logic [3:0] ros;
        logic       rie;
        logic [3:0] ris;
        logic       y;
        logic [1:0] aop;
        logic       zi;
        logic       zo;
        logic       imm;
        logic       mar;
        logic       mdrb;
        logic       mdro;
        logic       en;
        logic       rw;
        logic       pc;
        logic       dn;
        logic       hlt;
        logic       ill;
    } obs_t;

    logic clk = 1'b0;
    logic rst, done_fetch, MFC;
    logic [15:0] ir;
    logic reg_out_en, reg_in_en, y_in, z_in, z_out_en, imm_out_en;
    logic [3:0] reg_out_sel, reg_in_sel;
    logic [1:0] alu_op;
    logic MARin, MDR_frombusin, MDROutEn, EN, RW, PCin;
    logic done, halted, illegal;
`ifdef EXEC_MFC_TIMEOUT_EN
    logic bus_err;
`endif

    obs_t o, e;
    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    exec_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .done_fetch    (done_fetch),
        .ir            (ir),
        .MFC           (MFC),
        .reg_out_en    (reg_out_en),
        .reg_out_sel   (reg_out_sel),
        .reg_in_en     (reg_in_en),
        .reg_in_sel    (reg_in_sel),
        .y_in          (y_in),
        .alu_op        (alu_op),
        .z_in          (z_in),
        .z_out_en      (z_out_en),
        .imm_out_en    (imm_out_en),
        .MARin         (MARin),
        .MDR_frombusin (MDR_frombusin),
        .MDROutEn      (MDROutEn),
        .EN            (EN),
        .RW            (RW),
        .PCin          (PCin),
        .done          (done),
        .halted        (halted),
`ifdef EXEC_MFC_TIMEOUT_EN
        .bus_err       (bus_err),
`endif
        .illegal       (illegal)
    );

    assign o = {reg_out_en, reg_out_sel, reg_in_en, reg_in_sel, y_in,
                alu_op, z_in, z_out_en, imm_out_en, MARin,
                MDR_frombusin, MDROutEn, EN, RW, PCin,
                done, halted, illegal};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chkw(input string tag, input obs_t exp);
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] instr);
        done_fetch = 1'b1;
        ir = instr;
        tick;
        done_fetch = 1'b0;
        ir = 16'hFFFF;
    endtask

    initial begin
        rst = 1'b1;
        done_fetch = 1'b0;
        MFC = 1'b0;
        ir = 16'h0000;
        #1;
        e = '0;
        chkw("reset_outputs", e);
        tick;
        rst = 1'b0;
        tick;
        chkw("idle_after_reset", e);

        // ADD r2,r3
        start(16'h1230);
        e = '0; chkw("add_decode", e);
        tick;
        e = '0; e.roe = 1; e.ros = 4'd2; e.y = 1;
        chkw("add_A1", e);
        tick;
        e = '0; e.roe = 1; e.ros = 4'd3; e.aop = 2'b00; e.zi = 1;
        chkw("add_A2", e);
        tick;
        e = '0; e.zo = 1; e.rie = 1; e.ris = 4'd2;
        chkw("add_A3", e);
        tick;
        e = '0; e.dn = 1; chkw("add_done", e);
        tick;
        e = '0; chkw("add_idle", e);

        // OR r1,r2 : A2 must carry alu_op 11
        start(16'h4120);
        tick;
        e = '0; e.roe = 1; e.ros = 4'd1; e.y = 1;
        chkw("or_A1", e);
        tick;
        e = '0; e.roe = 1; e.ros = 4'd2; e.aop = 2'b11; e.zi = 1;
        chkw("or_A2", e);
        tick; tick; tick;

        // SUB r5,r6 : alu_op 01
        start(16'h2560);
        tick; tick;
        e = '0; e.roe = 1; e.ros = 4'd6; e.aop = 2'b01; e.zi = 1;
        chkw("sub_A2", e);
        tick; tick; tick;

        // LOAD r1,[r4], MFC after 3 extra cycles
        start(16'h5140);
        tick;
        e = '0; e.roe = 1; e.ros = 4'd4; e.mar = 1;
        chkw("load_L1", e);
        tick;
        e = '0; e.en = 1; e.rw = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) MFC = 1'b1;
            chkw("load_L2_wait", e);
            tick;
        end
        MFC = 1'b0;
        e = '0; e.mdro = 1; e.rie = 1; e.ris = 4'd1;
        chkw("load_L3", e);
        tick;
        e = '0; e.dn = 1; chkw("load_done", e);
        tick;
        e = '0; chkw("load_idle", e);

        // STORE [r2],r5 with MFC already high on entry to S3
        start(16'h6250);
        tick;
        e = '0; e.roe = 1; e.ros = 4'd2; e.mar = 1;
        chkw("store_S1", e);
        MFC = 1'b1;
        tick;
        e = '0; e.roe = 1; e.ros = 4'd5; e.mdrb = 1;
        chkw("store_S2", e);
        tick;
        e = '0; e.en = 1; chkw("store_S3", e);
        tick;
        MFC = 1'b0;
        e = '0; e.dn = 1; chkw("store_done_min_lat", e);
        tick;

        // MOVI r3,#45
        start(16'h7345);
        tick;
        e = '0; e.imm = 1; e.rie = 1; e.ris = 4'd3;
        chkw("movi_M1", e);
        tick;
        e = '0; e.dn = 1; chkw("movi_done", e);
        tick;

        // JMP r6
        start(16'h8060);
        tick;
        e = '0; e.roe = 1; e.ros = 4'd6; e.pc = 1;
        chkw("jmp_J1", e);
        tick;
        e = '0; e.dn = 1; chkw("jmp_done", e);
        tick;

        // NOP, with a stray done_fetch during DONE that must be ignored
        start(16'h0000);
        e = '0; chkw("nop_decode", e);
        tick;
        e = '0; e.dn = 1; chkw("nop_done", e);
        done_fetch = 1'b1;
        ir = 16'h7345;
        tick;
        done_fetch = 1'b0;
        tick; tick;
        e = '0; chkw("done_fetch_in_done_ignored", e);

        // Undefined opcode
        start(16'hA000);
        e = '0; e.ill = 1; chkw("illegal_decode", e);
        tick;
        e = '0; e.dn = 1; chkw("illegal_done", e);
        tick;
        e = '0; chkw("illegal_idle", e);

        // HALT is sticky until reset
        start(16'hF000);
        tick;
        e = '0; e.hlt = 1; chkw("halt_enter", e);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (done) n++;
        end
        chki("halt_no_done", n, 0);
        chkw("halt_still", e);
        #2 rst = 1'b1;
        #1;
        e = '0; chkw("halt_async_clear", e);
        tick;
        rst = 1'b0;
        tick;
        chkw("halt_idle_after_rst", e);

        // Reset during an L2 wait
        start(16'h5140);
        tick; tick;
        e = '0; e.en = 1; e.rw = 1;
        chkw("rst_pre_L2", e);
        #2 rst = 1'b1;
        #1;
        e = '0; chkw("rst_in_L2_async", e);
        tick;
        rst = 1'b0;
        tick; tick;
        chkw("rst_in_L2_idle", e);

`ifdef EXEC_MFC_TIMEOUT_EN
        // MFC never arrives: watchdog aborts the load
        start(16'h5140);
        tick; tick;
        n = 0;
        while (EN && n < 40) begin
            if (reg_in_en) n = 100;
            n++;
            tick;
        end
        chki("tmo_en_cycles", n, 15);
        chki("tmo_bus_err", int'(bus_err), 1);
        e = '0; chkw("tmo_berr_quiet", e);
        tick;
        chki("tmo_bus_err_pulse", int'(bus_err), 0);
        e = '0; e.dn = 1; chkw("tmo_done", e);
        tick;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
